// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor (LSB first, one bit per clock).
// Latency: done pulses WIDTH edges after the edge that accepts start; next start is accepted WIDTH+2 edges later.
// Backpressure: start is honoured only in IDLE; pulses while busy or done are dropped.
module serial_addsub_n #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    input  logic             Cin1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_carry_nx;

    // Only an idle block takes a new operation.
    assign w_accept   = (r_state == S_IDLE) && start;
    // Counter value WIDTH-1 means this edge consumes the MSB.
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
    // One full-adder slice over the current LSBs.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_nx = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; busy/done follow the state directly.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand load on accept, then one serial bit per edge while shifting.
    // Subtract is A + ~B + 1, so the stored carry seeds the +1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= DA;
            r_b     <= sub ? ~DB : DB;
            r_carry <= sub ? 1'b1 : Cin1;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_nx;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                // Signed overflow: carry into the MSB differs from carry out of it.
                r_cout <= w_carry_nx;
                r_ovf  <= r_carry ^ w_carry_nx;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n at WIDTH 8, 16 and 2.
// Arithmetic expectations come from integer math; the 8-bit instance is also tracked cycle by cycle.
module tb_serial_addsub_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        st8, sb8, ci8, bz8, dn8, co8, ov8;
    logic [7:0]  da8, db8, sm8;
    logic        st16, sb16, ci16, bz16, dn16, co16, ov16;
    logic [15:0] da16, db16, sm16;
    logic        st2, sb2, ci2, bz2, dn2, co2, ov2;
    logic [1:0]  da2, db2, sm2;

    int total = 0;
    int bad   = 0;

    serial_addsub_n #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .start(st8), .sub(sb8), .DA(da8), .DB(db8), .Cin1(ci8),
        .busy(bz8), .done(dn8), .Sum(sm8), .Cout(co8), .Ovf(ov8)
    );

    serial_addsub_n #(.WIDTH(16)) u_dut16 (
        .clock(clock), .reset(reset), .start(st16), .sub(sb16), .DA(da16), .DB(db16), .Cin1(ci16),
        .busy(bz16), .done(dn16), .Sum(sm16), .Cout(co16), .Ovf(ov16)
    );

    serial_addsub_n #(.WIDTH(2)) u_dut2 (
        .clock(clock), .reset(reset), .start(st2), .sub(sb2), .DA(da2), .DB(db2), .Cin1(ci2),
        .busy(bz2), .done(dn2), .Sum(sm2), .Cout(co2), .Ovf(ov2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference result from plain unsigned/signed integer arithmetic.
    function automatic void model(input int w, input logic [63:0] da, input logic [63:0] db,
                                  input logic s, input logic c,
                                  output logic [63:0] sum, output logic cout, output logic ovf);
        longint      sa, sb, r;
        logic [63:0] mask, full;
        mask = (64'd1 << w) - 64'd1;
        sa   = da[w-1] ? longint'(da) - (longint'(1) << w) : longint'(da);
        sb   = db[w-1] ? longint'(db) - (longint'(1) << w) : longint'(db);
        if (s) begin
            sum  = (da - db) & mask;
            cout = (da >= db);
            r    = sa - sb;
        end else begin
            full = da + db + 64'(c);
            sum  = full & mask;
            cout = full[w];
            r    = sa + sb + longint'(c);
        end
        ovf = (r > (longint'(1) << (w - 1)) - 1) || (r < -(longint'(1) << (w - 1)));
    endfunction

    // Cycle-level expectation for the 8-bit instance: edges elapsed since acceptance.
    bit          m_act = 1'b0;
    int          m_k   = 0;
    logic [63:0] m_sum = '0, p_sum;
    logic        m_co  = 1'b0, m_ov = 1'b0, p_co, p_ov;
    bit          m_vld = 1'b1;
    bit          chk_en = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_act = 1'b0; m_k = 0; m_sum = '0; m_co = 1'b0; m_ov = 1'b0; m_vld = 1'b1;
        end else if (m_act) begin
            m_k++;
            if (m_k == 8) begin
                m_sum = p_sum; m_co = p_co; m_ov = p_ov; m_vld = 1'b1;
            end
            if (m_k > 8) m_act = 1'b0;
        end else if (st8) begin
            m_act = 1'b1;
            m_k   = 0;
            m_vld = 1'b0;
            model(8, 64'(da8), 64'(db8), sb8, ci8, p_sum, p_co, p_ov);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy8", 64'(bz8), 64'(m_act && m_k < 8));
            check("done8", 64'(dn8), 64'(m_act && m_k == 8));
            if (m_vld) begin
                check("sum8", 64'(sm8), m_sum);
                check("cout8", 64'(co8), 64'(m_co));
                check("ovf8", 64'(ov8), 64'(m_ov));
            end
        end
    end

    function automatic logic get_done(input int w);
        case (w)
            8:       return dn8;
            16:      return dn16;
            default: return dn2;
        endcase
    endfunction

    task automatic op(input int w, input logic [63:0] a, input logic [63:0] b, input logic s, input logic c,
                      input logic [63:0] es, input logic eco, input logic eov, input string tag);
        int          lat;
        logic [63:0] os, ms;
        logic        oc, ov, mc, mv;
        case (w)
            8:       begin da8 = a[7:0];  db8 = b[7:0];  sb8 = s;  ci8 = c;  st8 = 1'b1;  end
            16:      begin da16 = a[15:0]; db16 = b[15:0]; sb16 = s; ci16 = c; st16 = 1'b1; end
            default: begin da2 = a[1:0];  db2 = b[1:0];  sb2 = s;  ci2 = c;  st2 = 1'b1;  end
        endcase
        @(negedge clock);
        st8 = 1'b0; st16 = 1'b0; st2 = 1'b0;
        // Operand changes after acceptance must not disturb the running operation.
        da8 = ~da8; db8 = ~db8; sb8 = ~sb8; ci8 = ~ci8;
        da16 = ~da16; db16 = ~db16; sb16 = ~sb16; ci16 = ~ci16;
        da2 = ~da2; db2 = ~db2; sb2 = ~sb2; ci2 = ~ci2;
        lat = 0;
        while (!get_done(w) && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(w));
        case (w)
            8:       begin os = 64'(sm8);  oc = co8;  ov = ov8;  end
            16:      begin os = 64'(sm16); oc = co16; ov = ov16; end
            default: begin os = 64'(sm2);  oc = co2;  ov = ov2;  end
        endcase
        check({tag, " sum"}, os, es);
        check({tag, " cout"}, 64'(oc), 64'(eco));
        check({tag, " ovf"}, 64'(ov), 64'(eov));
        if (w != 8) begin
            model(w, a, b, s, c, ms, mc, mv);
            check({tag, " sum model"}, os, ms);
            check({tag, " cout model"}, 64'(oc), 64'(mc));
            check({tag, " ovf model"}, 64'(ov), 64'(mv));
        end
        @(negedge clock);
    endtask

    initial begin
        int nb, nd;
        reset = 1'b1;
        st8 = 0; sb8 = 0; ci8 = 0; da8 = 0; db8 = 0;
        st16 = 0; sb16 = 0; ci16 = 0; da16 = 0; db16 = 0;
        st2 = 0; sb2 = 0; ci2 = 0; da2 = 0; db2 = 0;
        repeat (3) @(negedge clock);
        check("reset busy", 64'(bz8), 0);
        check("reset done", 64'(dn8), 0);
        check("reset sum", 64'(sm8), 0);
        check("reset cout", 64'(co8), 0);
        check("reset ovf", 64'(ov8), 0);
        check("reset sum16", 64'(sm16), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        // Handshake: extra start pulses in SHIFT (cycle 3) and DONE (cycle 8) are dropped.
        da8 = 8'd10; db8 = 8'd20; sb8 = 1'b0; ci8 = 1'b0; st8 = 1'b1;
        nb = 0; nd = 0;
        for (int n = 0; n <= 12; n++) begin
            @(negedge clock);
            st8 = (n == 3 || n == 8);
            if (n == 3) begin da8 = 8'd77; db8 = 8'd11; sb8 = 1'b1; end
            if (bz8) nb++;
            if (dn8) nd++;
        end
        check("hs busy cycles", 64'(nb), 8);
        check("hs done cycles", 64'(nd), 1);
        check("hs sum", 64'(sm8), 30);
        st8 = 1'b0;
        @(negedge clock);

        op(8, 100, 55, 0, 0, 155, 0, 1, "add 100+55");
        op(8, 200, 100, 0, 0, 44, 1, 0, "add 200+100");
        op(8, 5, 3, 1, 0, 2, 1, 0, "sub 5-3");
        op(8, 3, 5, 1, 0, 254, 0, 0, "sub 3-5");
        op(8, 255, 0, 0, 1, 0, 1, 0, "add 255+0+1");
        op(8, 127, 1, 0, 0, 128, 0, 1, "add 127+1");
        op(8, 128, 1, 1, 0, 127, 1, 1, "sub 128-1");

        // Reset in the middle of an operation, between clock edges.
        da8 = 8'd50; db8 = 8'd60; sb8 = 1'b0; ci8 = 1'b0; st8 = 1'b1;
        @(negedge clock);
        st8 = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort busy", 64'(bz8), 0);
        check("abort done", 64'(dn8), 0);
        check("abort sum", 64'(sm8), 0);
        check("abort cout", 64'(co8), 0);
        check("abort ovf", 64'(ov8), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clock);
            if (dn8) nd++;
        end
        check("abort no done", 64'(nd), 0);
        op(8, 50, 60, 0, 0, 110, 0, 0, "after reset");

        op(16, 40000, 30000, 0, 0, 4464, 1, 0, "w16 add");
        op(2, 3, 1, 0, 0, 0, 1, 0, "w2 add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub_n.md
SERIAL_ADDSUB_N -- requirements
Module: serial_addsub_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled on a rising clock edge.
REQ-005 The block SHALL have port sub, input, 1 bit: operation select sampled with start; 0 = add, 1 = subtract (DA - DB).
REQ-006 The block SHALL have ports DA and DB, inputs, WIDTH bits each: operands sampled with start.
REQ-007 The block SHALL have port Cin1, input, 1 bit: carry-in for add, sampled with start; ignored when sub=1.
REQ-008 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed result.
REQ-010 The block SHALL have port Sum, output, WIDTH bits: the result register.
REQ-011 The block SHALL have port Cout, output, 1 bit: final carry out; for subtract, 1 = no borrow.
REQ-012 The block SHALL have port Ovf, output, 1 bit: two's-complement signed overflow of the completed operation.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL, at that edge:
- load A<=DA, and B<=DB (sub=0) or ~DB (sub=1);
- load carry<=Cin1 (sub=0) or 1 (sub=1);
- clear the bit counter and Sum;
- enter SHIFT.
REQ-015 In SHIFT, each edge SHALL process one bit, LSB first:
- s = A[0]^B[0]^carry;
- carry <= majority(A[0],B[0],carry);
- A and B shift right one place;
- Sum shifts right with s inserted at Sum[WIDTH-1];
- the counter increments.
REQ-016 The bit counter SHALL be $clog2(WIDTH+1) bits wide; on the edge processing bit WIDTH-1, the FSM SHALL enter DONE.
REQ-017 On the last-bit edge, Cout SHALL be loaded with the final carry, and Ovf with (carry into MSB) XOR (carry out of MSB).
REQ-018 Timing SHALL be as follows:
- busy=1 exactly while in SHIFT, i.e. WIDTH cycles;
- done=1 exactly while in DONE, i.e. one cycle;
- done rises WIDTH edges after the edge that accepted start.
REQ-019 DONE SHALL return to IDLE at the next edge unconditionally; start in DONE SHALL be ignored.
REQ-020 start while in SHIFT or DONE SHALL be ignored, with no effect on operands, counter or result.
REQ-021 Sum, Cout and Ovf SHALL hold their completed values from DONE until the next accepted start.
REQ-022 Changes on DA, DB, sub and Cin1 outside the accepting edge SHALL NOT affect an operation in progress.
REQ-023 Back-to-back operations SHALL have a minimum start-to-start spacing of WIDTH+2 cycles.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; Sum = (DA+DB+Cin1) mod 2^WIDTH for add, and (DA-DB) mod 2^WIDTH for subtract.

Reset
REQ-025 While reset=1, asynchronously and without waiting for clock, the block SHALL:
- force state to IDLE;
- clear busy, done, Sum, Cout, Ovf, A, B, carry and the counter.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no done pulse for it SHALL ever appear.
REQ-027 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8 unless noted)
REQ-028 The bench SHALL cover add: DA=100, DB=55, sub=0, Cin1=0, start -> done after 8 cycles with Sum=155, Cout=0, Ovf=1; then DA=200, DB=100 -> Sum=44, Cout=1.
REQ-029 The bench SHALL cover subtract: DA=5, DB=3, sub=1 -> Sum=2, Cout=1, Ovf=0; then DA=3, DB=5, sub=1 -> Sum=254, Cout=0, Ovf=0.
REQ-030 The bench SHALL cover carry-in and overflow:
- DA=255, DB=0, Cin1=1, sub=0 -> Sum=0, Cout=1;
- DA=127, DB=1 -> Sum=128, Ovf=1;
- DA=128, DB=1, sub=1 -> Sum=127, Ovf=1.
REQ-031 The bench SHALL cover handshake: pulse start again at cycles 3 and 8 after acceptance with different operands -> first result unchanged, busy high for exactly 8 cycles, done high for exactly 1 cycle.
REQ-032 The bench SHALL cover reset mid-operation: assert reset 4 cycles after start, between clock edges -> outputs 0 immediately, no done pulse; the next start produces a correct result.
REQ-033 The bench SHALL cover parametrisation: WIDTH=16, DA=40000, DB=30000, sub=0 -> done after 16 cycles with Sum=4464, Cout=1; WIDTH=2, DA=3, DB=1 -> Sum=0, Cout=1.
